// File: rtl/mf_pager.sv
// Multiface-style NMI pager: arms NMI from the front-panel key, pages in an
// overlay ROM/RAM window, and mirrors write-only hardware registers into overlay RAM.
module mf_pager #(
  parameter int          RAM_AW    = 13,
  parameter logic [15:0] NMI_VEC   = 16'h0066,
  parameter logic [15:0] HIDE_VEC  = 16'h0065,
  parameter int          CRTC_REGS = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        key_nmi,
  input  logic        m1,
  input  logic        io_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic        nmi,
  output logic        mf_en,
  output logic        mf_hidden,
  output logic        rom_en,
  output logic        ram_en,
  output logic [7:0]  dout
);

  localparam int BW = (RAM_AW > 13) ? RAM_AW - 13 : 1;
  localparam int CW = $clog2(CRTC_REGS);
  localparam logic [RAM_AW-1:0] TOP_BASE  = RAM_AW'((2 ** RAM_AW) - 8192);
  localparam logic [12:0]       CRTC_BASE = 13'(32'h1DC0 - CRTC_REGS);

  typedef enum logic [2:0] {IDLE, ARMED, PAGED, PAGED_HID, OUT_HID} state_t;

  state_t          state, nxt;
  logic            key_q, m1_q, io_q;
  logic            key_rise, m1_rise, io_rise;
  logic            pagein_wr, pageout_wr, bank_wr;
  logic [BW-1:0]   bank;
  logic [4:0]      pen, creg;
  logic            shadow_hit;
  logic [12:0]     shadow_off;
  logic [RAM_AW-1:0] cpu_ram_addr, ram_wa;
  logic            ram_we;
  logic [7:0]      rd_q;
  logic [7:0]      ram [2**RAM_AW];

  assign key_rise   = key_nmi & ~key_q;
  assign m1_rise    = m1 & ~m1_q;
  assign io_rise    = io_wr & ~io_q;
  assign pagein_wr  = io_rise && (cpu_addr == 16'hFEE8);
  assign pageout_wr = io_rise && (cpu_addr == 16'hFEEA);
  assign bank_wr    = io_rise && (cpu_addr == 16'hFEEC);

  assign rom_en = mf_en && (cpu_addr[15:13] == 3'd0);
  assign ram_en = mf_en && (cpu_addr[15:13] == 3'd1);
  assign dout   = (ram_en && mem_rd) ? rd_q : 8'hFF;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (pagein_wr) nxt = PAGED;
                 else if (key_rise) nxt = ARMED;
      ARMED:     if (pagein_wr) nxt = PAGED;
                 else if (m1_rise && cpu_addr == NMI_VEC) nxt = PAGED;
      PAGED:     if (pageout_wr) nxt = IDLE;
                 else if (m1_rise && cpu_addr == HIDE_VEC) nxt = PAGED_HID;
      PAGED_HID: if (pageout_wr) nxt = OUT_HID;
      OUT_HID:   if (key_rise) nxt = ARMED;
      default:   nxt = IDLE;
    endcase
  end

  // Shadow offsets are within the top 8 KiB bank of overlay RAM.
  always_comb begin
    shadow_hit = 1'b0;
    shadow_off = '0;
    if (io_rise) begin
      shadow_hit = 1'b1;
      unique case (cpu_addr[15:8])
        8'h7F: begin
          unique case (cpu_dout[7:6])
            2'b00: shadow_off = 13'h1FCF;
            2'b01: shadow_off = pen[4] ? 13'h1FDF : {9'h1F9, pen[3:0]};
            2'b10: shadow_off = 13'h1FEF;
            default: shadow_off = 13'h1FFF;
          endcase
        end
        8'hBC:   shadow_off = 13'h1CFF;
        8'hBD:   shadow_off = CRTC_BASE + 13'(creg[CW-1:0]);
        8'hF7:   shadow_off = 13'h17FF;
        8'hDF:   shadow_off = 13'h1AAC;
        default: shadow_hit = 1'b0;
      endcase
    end
  end

  // Bank bits fall off the top when there is only one bank.
  assign cpu_ram_addr = RAM_AW'({bank, cpu_addr[12:0]});
  assign ram_we = shadow_hit || (mem_wr && ram_en);
  assign ram_wa = shadow_hit ? (TOP_BASE | RAM_AW'(shadow_off)) : cpu_ram_addr;

  always_ff @(posedge clk_sys) begin
    if (ram_we) ram[ram_wa] <= cpu_dout;
    else        rd_q <= ram[cpu_ram_addr];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      nmi       <= 1'b0;
      mf_en     <= 1'b0;
      mf_hidden <= 1'b0;
      bank      <= '0;
      pen       <= '0;
      creg      <= '0;
      key_q     <= 1'b0;
      m1_q      <= 1'b0;
      io_q      <= 1'b0;
    end else begin
      key_q     <= key_nmi;
      m1_q      <= m1;
      io_q      <= io_wr;
      state     <= nxt;
      nmi       <= (nxt == ARMED);
      mf_en     <= (nxt == PAGED) || (nxt == PAGED_HID);
      mf_hidden <= (nxt == PAGED_HID) || (nxt == OUT_HID);
      if (bank_wr && RAM_AW > 13) bank <= cpu_dout[BW-1:0];
      if (io_rise && cpu_addr[15:8] == 8'h7F && cpu_dout[7:6] == 2'b00) pen <= cpu_dout[4:0];
      if (io_rise && cpu_addr[15:8] == 8'hBC) creg <= cpu_dout[4:0];
    end
  end

endmodule

// File: tb/tb_mf_pager.sv
// Bench for mf_pager: 8 KiB and 32 KiB instances share stimulus and are
// checked against a flag-based pager model and byte-array RAM images.
module tb_mf_pager;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_nmi = 1'b0, m1 = 1'b0, io_wr = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;

  logic nmi_a, en_a, hid_a, rom_a, ram_a;
  logic nmi_b, en_b, hid_b, rom_b, ram_b;
  logic [7:0] dout_a, dout_b;

  int n_cmp = 0;
  int n_err = 0;

  bit   m_armed, m_paged, m_hidden;
  int   m_bank, m_pen, m_creg;
  logic [7:0] img_a [8192];
  logic [7:0] img_b [32768];
  bit   known_a [8192];
  bit   known_b [32768];

  always #5 clk = ~clk;

  mf_pager u_a (
    .clk_sys(clk), .reset(reset), .key_nmi(key_nmi), .m1(m1), .io_wr(io_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .nmi(nmi_a), .mf_en(en_a), .mf_hidden(hid_a), .rom_en(rom_a), .ram_en(ram_a),
    .dout(dout_a)
  );

  mf_pager #(.RAM_AW(15)) u_b (
    .clk_sys(clk), .reset(reset), .key_nmi(key_nmi), .m1(m1), .io_wr(io_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .nmi(nmi_b), .mf_en(en_b), .mf_hidden(hid_b), .rom_en(rom_b), .ram_en(ram_b),
    .dout(dout_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_armed = 0; m_paged = 0; m_hidden = 0;
    m_bank = 0; m_pen = 0; m_creg = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".nmi_a"}, {7'd0, nmi_a}, {7'd0, m_armed});
    chk({tag, ".en_a"},  {7'd0, en_a},  {7'd0, m_paged});
    chk({tag, ".hid_a"}, {7'd0, hid_a}, {7'd0, m_hidden});
    chk({tag, ".nmi_b"}, {7'd0, nmi_b}, {7'd0, m_armed});
    chk({tag, ".en_b"},  {7'd0, en_b},  {7'd0, m_paged});
    chk({tag, ".hid_b"}, {7'd0, hid_b}, {7'd0, m_hidden});
  endtask

  task automatic model_io(input logic [15:0] a, input logic [7:0] d);
    int off;
    off = -1;
    if (a == 16'hFEE8) begin
      if (!m_hidden) begin m_paged = 1; m_armed = 0; end
    end else if (a == 16'hFEEA) begin
      m_paged = 0;
    end else if (a == 16'hFEEC) begin
      m_bank = int'(d) % 4;
    end else begin
      case (a[15:8])
        8'h7F: case (d[7:6])
          2'b00: begin off = 'h1FCF; m_pen = int'(d) % 32; end
          2'b01: off = (m_pen >= 16) ? 'h1FDF : 'h1F90 + (m_pen % 16);
          2'b10: off = 'h1FEF;
          default: off = 'h1FFF;
        endcase
        8'hBC: begin off = 'h1CFF; m_creg = int'(d) % 32; end
        8'hBD: off = ('h1DC0 - 16) + (m_creg % 16);
        8'hF7: off = 'h17FF;
        8'hDF: off = 'h1AAC;
        default: off = -1;
      endcase
    end
    if (off >= 0) begin
      img_a[off] = d; known_a[off] = 1;
      img_b['h6000 + off] = d; known_b['h6000 + off] = 1;
    end
  endtask

  task automatic io_out(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; io_wr = 1;
    step();
    model_io(a, d);
    io_wr = 0;
    step();
    check_state("io");
  endtask

  task automatic m1_cycle(input logic [15:0] a);
    cpu_addr = a; m1 = 1;
    step();
    if (m_armed && a == 16'h0066) begin m_armed = 0; m_paged = 1; m_hidden = 0; end
    else if (m_paged && !m_hidden && a == 16'h0065) m_hidden = 1;
    m1 = 0;
    step();
    check_state("m1");
  endtask

  task automatic key_press();
    key_nmi = 1;
    step();
    if (!m_paged && !m_armed) begin m_armed = 1; m_hidden = 0; end
    key_nmi = 0;
    step();
    check_state("key");
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
    int ia, ib;
    cpu_addr = a; cpu_dout = d; mem_wr = 1;
    step();
    if (m_paged && a[15:13] == 3'd1) begin
      ia = int'(a[12:0]);
      ib = m_bank * 8192 + int'(a[12:0]);
      img_a[ia] = d; known_a[ia] = 1;
      img_b[ib] = d; known_b[ib] = 1;
    end
    mem_wr = 0;
  endtask

  task automatic mem_read(input logic [15:0] a);
    bit in_ram, in_rom;
    int ia, ib;
    cpu_addr = a; mem_rd = 1;
    step();
    in_ram = m_paged && a[15:13] == 3'd1;
    in_rom = m_paged && a[15:13] == 3'd0;
    ia = int'(a[12:0]);
    ib = m_bank * 8192 + int'(a[12:0]);
    chk("ram_en_a", {7'd0, ram_a}, {7'd0, in_ram});
    chk("rom_en_b", {7'd0, rom_b}, {7'd0, in_rom});
    if (!in_ram) begin
      chk("dout_a_ff", dout_a, 8'hFF);
      chk("dout_b_ff", dout_b, 8'hFF);
    end else begin
      if (known_a[ia]) chk("dout_a", dout_a, img_a[ia]);
      if (known_b[ib]) chk("dout_b", dout_b, img_b[ib]);
    end
    mem_rd = 0;
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    int op;

    model_reset();
    #3;
    chk("rst_nmi", {7'd0, nmi_a}, 8'd0);
    chk("rst_en", {7'd0, en_b}, 8'd0);
    chk("rst_dout", dout_a, 8'hFF);
    @(negedge clk);
    reset = 0;
    step();
    check_state("after_rst");

    // NMI arm and acceptance
    key_press();
    m1_cycle(16'h0038);
    m1_cycle(16'h0066);
    cpu_addr = 16'h0100;
    #1;
    chk("rom_en_0100", {7'd0, rom_a}, {7'd0, m_paged});
    chk("rom_en_0100_lit", {7'd0, rom_a}, 8'd1);

    mem_write(16'h2005, 8'h5A);
    mem_read(16'h2005);
    chk("dout_5a", dout_a, 8'h5A);
    mem_read(16'h4005);
    mem_write(16'h0005, 8'h11);
    mem_read(16'h0005);

    // Hide, page out, re-arm
    m1_cycle(16'h0065);
    io_out(16'hFEEA, 8'h00);
    io_out(16'hFEE8, 8'h00);
    chk("hid_no_pagein", {7'd0, en_a}, 8'd0);
    key_press();
    m1_cycle(16'h0066);
    chk("hid_cleared", {7'd0, hid_a}, 8'd0);
    io_out(16'hFEEA, 8'h00);

    // Shadow capture while unpaged
    io_out(16'h7F00, 8'h03);
    io_out(16'h7F00, 8'h4C);
    io_out(16'hFEE8, 8'h00);
    mem_read(16'h3F93);
    chk("pen_shadow", dout_a, 8'h4C);
    mem_read(16'h3FCF);
    chk("pen_sel_shadow", dout_a, 8'h03);
    io_out(16'hBC00, 8'h0C);
    io_out(16'hBD00, 8'h30);
    mem_read(16'h3DBC);
    chk("crtc_shadow", dout_a, 8'h30);

    // Banking on the 32 KiB instance
    io_out(16'hFEEC, 8'h00);
    mem_write(16'h2010, 8'h55);
    io_out(16'hFEEC, 8'h01);
    mem_write(16'h2010, 8'hAA);
    io_out(16'hFEEC, 8'h00);
    mem_read(16'h2010);
    chk("bank0_b", dout_b, 8'h55);
    io_out(16'hF700, 8'h82);
    io_out(16'hFEEC, 8'h03);
    mem_read(16'h37FF);
    chk("f7_shadow_b", dout_b, 8'h82);
    io_out(16'hFEEC, 8'h00);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 9));
      d = 8'($urandom);
      case (op)
        0, 1: begin
          case ($urandom_range(0, 8))
            0: a = 16'hFEE8;
            1: a = 16'hFEEA;
            2: a = 16'hFEEC;
            3: a = {8'h7F, 8'($urandom)};
            4: a = {8'hBC, 8'($urandom)};
            5: a = {8'hBD, 8'($urandom)};
            6: a = {8'hF7, 8'($urandom)};
            7: a = {8'hDF, 8'($urandom)};
            default: a = 16'($urandom);
          endcase
          io_out(a, d);
        end
        2: m1_cycle(($urandom_range(0, 2) == 0) ? 16'($urandom) :
                    (($urandom_range(0, 1) == 0) ? 16'h0066 : 16'h0065));
        3: key_press();
        4, 5: mem_write(16'($urandom_range(0, 16'h5FFF)), d);
        default: mem_read(16'($urandom_range(0, 16'h5FFF)));
      endcase
    end

    // Asynchronous reset from PAGED_HID
    reset = 1;
    #2;
    model_reset();
    reset = 0;
    step();
    key_press();
    m1_cycle(16'h0066);
    m1_cycle(16'h0065);
    key_press();
    cpu_addr = 16'h2000;
    mem_rd = 1;
    #2;
    reset = 1;
    #1;
    model_reset();
    chk("arst_nmi", {7'd0, nmi_a}, 8'd0);
    chk("arst_en", {7'd0, en_a}, 8'd0);
    chk("arst_hid", {7'd0, hid_b}, 8'd0);
    chk("arst_ram_en", {7'd0, ram_a}, 8'd0);
    chk("arst_dout", dout_b, 8'hFF);
    mem_rd = 0;
    @(negedge clk);
    reset = 0;
    step();
    key_press();
    chk("rearm_nmi", {7'd0, nmi_b}, 8'd1);
    m1_cycle(16'h0066);
    mem_read(16'h3DBC);
    mem_read(16'h3F93);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
